// File: rtl/instr_feeder.sv
// Instruction feeder for proc: small writable program memory, a program counter and an
// issue/wait handshake that stops on program length, a stop request or a Done timeout.
module instr_feeder #(
    parameter int ADDR_W  = 5,
    parameter int TIMEOUT = 8
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [15:0]       LoadData,
    input  logic [ADDR_W:0]   ProgLen,
    input  logic              Start,
    input  logic              Stop,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic              Busy,
    output logic              Halted,
    output logic              Fault,
    output logic [ADDR_W:0]   PC,
    output logic [15:0]       InstrCount
);

    // state | meaning
    // IDLE  | waiting for Start; memory writable
    // ISSUE | Run high, DIN carries mem[PC]
    // WAIT  | waiting for Done from the processor, timeout counter running
    // END   | program finished (Halted) or timed out (Fault); memory writable
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_END} state_t;

    state_t            state;
    logic [15:0]       mem [2**ADDR_W];
    logic [ADDR_W:0]   len_q;
    logic [ADDR_W:0]   pc_inc;
    logic [7:0]        tmo_cnt;
    logic              stop_pend;

    assign Busy   = (state == S_ISSUE) || (state == S_WAIT);
    assign Run    = (state == S_ISSUE);
    assign DIN    = (state == S_ISSUE) ? mem[PC[ADDR_W-1:0]] : 16'h0000;
    assign pc_inc = PC + (ADDR_W+1)'(1);

    // Memory is intentionally left out of reset so a program survives a processor restart.
    always_ff @(posedge Clock) begin
        if (LoadEn && ((state == S_IDLE) || (state == S_END)))
            mem[LoadAddr] <= LoadData;
    end

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state      <= S_IDLE;
            PC         <= '0;
            InstrCount <= '0;
            Halted     <= 1'b0;
            Fault      <= 1'b0;
            len_q      <= '0;
            tmo_cnt    <= '0;
            stop_pend  <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_END: begin
                    if (!Stop && Start) begin
                        PC         <= '0;
                        InstrCount <= '0;
                        Fault      <= 1'b0;
                        len_q      <= ProgLen;
                        stop_pend  <= 1'b0;
                        if (ProgLen != '0) begin
                            Halted <= 1'b0;
                            state  <= S_ISSUE;
                        end else begin
                            Halted <= 1'b1;
                            state  <= S_END;
                        end
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    if (Stop)
                        stop_pend <= 1'b1;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (Done) begin
                        InstrCount <= InstrCount + 16'd1;
                        PC         <= pc_inc;
                        stop_pend  <= 1'b0;
                        if (pc_inc == len_q) begin
                            Halted <= 1'b1;
                            state  <= S_END;
                        end else if (stop_pend || Stop) begin
                            state <= S_IDLE;
                        end else begin
                            state <= S_ISSUE;
                        end
                    end else if (tmo_cnt == 8'(TIMEOUT - 1)) begin
                        Fault     <= 1'b1;
                        stop_pend <= 1'b0;
                        state     <= S_END;
                    end else begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                        // a stop seen while executing is held until the instruction completes
                        if (Stop)
                            stop_pend <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_feeder.sv
// Bench for instr_feeder: a processor model with per-instruction latency and a
// run-level reference model predicting issue cycles, DIN values and the final status.
module tb_instr_feeder;
    localparam int ADDR_W  = 5;
    localparam int TIMEOUT = 8;

    logic              Clock = 1'b0;
    logic              Resetn, LoadEn, Start, Stop, Done;
    logic [ADDR_W-1:0] LoadAddr;
    logic [15:0]       LoadData, DIN, InstrCount;
    logic [ADDR_W:0]   ProgLen, PC;
    logic              Run, Busy, Halted, Fault;

    instr_feeder #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Resetn(Resetn), .LoadEn(LoadEn), .LoadAddr(LoadAddr),
        .LoadData(LoadData), .ProgLen(ProgLen), .Start(Start), .Stop(Stop),
        .DIN(DIN), .Run(Run), .Done(Done), .Busy(Busy), .Halted(Halted),
        .Fault(Fault), .PC(PC), .InstrCount(InstrCount)
    );

    always #5 Clock = ~Clock;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] shadow [2**ADDR_W];
    int          lat [64];
    int          issue_idx = 0;
    int          wait_left = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Processor model: Done rises in the lat-th WAIT cycle of each issued instruction.
    always @(posedge Clock) begin
        #1;
        if (!Resetn) begin
            wait_left = 0;
            Done = 1'b0;
        end else if (Run) begin
            wait_left = lat[issue_idx];
            issue_idx++;
            Done = 1'b0;
        end else if (wait_left > 0) begin
            Done = (wait_left == 1);
            wait_left--;
        end else begin
            Done = 1'b0;
        end
    end

    task automatic load(input int a, input logic [15:0] d);
        LoadEn = 1'b1; LoadAddr = ADDR_W'(a); LoadData = d;
        @(posedge Clock); #1;
        LoadEn = 1'b0;
        shadow[a] = d;
    endtask

    // Runs a program of len instructions with latencies lat[]; optional one-cycle Stop at
    // cycle stop_at and a (blocked) write of 0xFFFF to address 1 at cycle ld_at.
    task automatic run_prog(input string nm, input int len, input int stop_at, input int ld_at);
        int exp_run[$];
        int got_run[$];
        logic [15:0] got_din[$];
        int r, cnt, exp_end, c;
        bit exp_halt, exp_fault;
        r = 1; cnt = 0; exp_halt = 0; exp_fault = 0; exp_end = 1;
        if (len == 0) exp_halt = 1;
        for (int i = 0; i < len; i++) begin
            exp_run.push_back(r);
            if (lat[i] > TIMEOUT) begin
                exp_fault = 1; exp_end = r + TIMEOUT + 1;
                break;
            end
            cnt++;
            exp_end = r + lat[i] + 1;
            if (cnt == len) begin exp_halt = 1; break; end
            if (stop_at >= r && stop_at <= r + lat[i]) break;
            r += lat[i] + 1;
        end

        issue_idx = 0;
        ProgLen = (ADDR_W+1)'(len);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        c = 1;
        forever begin
            if (Run) begin
                got_run.push_back(c);
                got_din.push_back(DIN);
            end
            if (!Busy || c >= 400) break;
            Stop = (c == stop_at);
            LoadEn = (c == ld_at); LoadAddr = ADDR_W'(1); LoadData = 16'hFFFF;
            @(posedge Clock); #1;
            c++;
        end
        Stop = 1'b0; LoadEn = 1'b0;

        chk({nm, "_end_cycle"}, c, exp_end);
        chk({nm, "_runs"}, got_run.size(), exp_run.size());
        for (int i = 0; i < got_run.size() && i < exp_run.size(); i++) begin
            chk($sformatf("%s_run%0d_cyc", nm, i), got_run[i], exp_run[i]);
            chk($sformatf("%s_run%0d_din", nm, i), got_din[i], shadow[i]);
        end
        chk({nm, "_pc"}, PC, cnt);
        chk({nm, "_icount"}, InstrCount, cnt);
        chk({nm, "_halted"}, Halted, exp_halt);
        chk({nm, "_fault"}, Fault, exp_fault);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int len, p, st;
        Resetn = 1'b0; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
        ProgLen = '0; Start = 1'b0; Stop = 1'b0; Done = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_pc", PC, 0);
        chk("rst_icount", InstrCount, 0);
        chk("rst_halted", Halted, 0);
        chk("rst_fault", Fault, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_run", Run, 0);
        chk("rst_din", DIN, 0);
        Resetn = 1'b1;

        for (int i = 0; i < 2**ADDR_W; i++) load(i, 16'($urandom));
        load(0, 16'h1005); load(1, 16'h3212); load(2, 16'h5003); load(3, 16'h6001);

        // mv, mvt, add: Run in cycles 1,3,5 and Halted visible at cycle 9
        lat[0] = 1; lat[1] = 1; lat[2] = 3;
        run_prog("prog3", 3, 0, 0);

        // Stop in the second WAIT cycle of the add: finish it, then park in IDLE at PC=3
        lat[3] = 1;
        run_prog("stop", 4, 7, 0);

        Start = 1'b1; Stop = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0; Stop = 1'b0;
        chk("startstop_busy", Busy, 0);
        chk("startstop_pc", PC, 3);
        chk("startstop_icount", InstrCount, 3);

        lat[0] = 255;
        run_prog("timeout", 2, 0, 0);
        lat[0] = TIMEOUT; lat[1] = TIMEOUT + 1;
        run_prog("tmo_edge", 2, 0, 0);

        run_prog("len0", 0, 0, 0);

        lat[0] = 1; lat[1] = 3;
        run_prog("ldbusy", 2, 2, 2);
        load(1, 16'hFFFF);
        lat[0] = 1; lat[1] = 1;
        run_prog("ldend", 2, 0, 0);

        // reset while the processor is still executing
        lat[0] = 6;
        issue_idx = 0;
        ProgLen = (ADDR_W+1)'(3);
        Start = 1'b1;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (2) @(posedge Clock);
        #1;
        chk("midwait_busy", Busy, 1);
        Resetn = 1'b0;
        @(posedge Clock); #1;
        Resetn = 1'b1;
        chk("rstwait_pc", PC, 0);
        chk("rstwait_icount", InstrCount, 0);
        chk("rstwait_run", Run, 0);
        chk("rstwait_din", DIN, 0);
        chk("rstwait_busy", Busy, 0);

        for (int n = 0; n < 25; n++) begin
            len = $urandom_range(1, 10);
            for (int i = 0; i < len; i++) begin
                p = $urandom_range(0, 19);
                if (p == 0) lat[i] = 255;
                else if (p == 1) lat[i] = TIMEOUT;
                else if (p == 2) lat[i] = TIMEOUT + 1;
                else lat[i] = $urandom_range(1, 4);
            end
            st = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 30) : 0;
            if ($urandom_range(0, 3) == 0) load($urandom_range(0, 9), 16'($urandom));
            run_prog($sformatf("rnd%0d", n), len, st, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/instr_feeder.md
# instr_feeder

Program-sequencing stage that sits directly upstream of `proc`. It holds a small writable instruction memory and a program counter. It presents one 16-bit instruction at a time on the processor's `DIN` with a one-cycle `Run` pulse, then waits for `Done`. It stops after a programmed length, on a stop request, or on a handshake timeout.

## Interface
Parameters:
- `ADDR_W`, default 5: instruction memory address width. Depth is `2**ADDR_W` words of 16 bits.
- `TIMEOUT`, default 8: maximum number of WAIT cycles without `Done` before a fault. Legal range is 5..255.

Ports:
- `Clock`, in, 1: clock; every register updates on the rising edge.
- `Resetn`, in, 1: reset. Synchronous, active-low; clock `Clock`.
- `LoadEn`, in, 1: write strobe for the instruction memory.
- `LoadAddr`, in, `ADDR_W`: write address.
- `LoadData`, in, 16: write data.
- `ProgLen`, in, `ADDR_W+1`: number of instructions to execute, 0..`2**ADDR_W`. Sampled on `Start`.
- `Start`, in, 1: begin execution at address 0.
- `Stop`, in, 1: request a halt after the current instruction completes.
- `DIN`, out, 16: instruction to the processor.
- `Run`, out, 1: instruction-valid pulse to the processor.
- `Done`, in, 1: the processor's combinational completion flag.
- `Busy`, out, 1: high in ISSUE or WAIT.
- `Halted`, out, 1: program ran to `ProgLen`.
- `Fault`, out, 1: timeout occurred.
- `PC`, out, `ADDR_W+1`: current program counter.
- `InstrCount`, out, 16: number of completed instructions since the last `Start`; wraps modulo 2^16.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, END. END is a single state for both normal end and fault; the two are told apart by `Fault`.
- Reset (`Resetn`=0 at an edge) forces the following values:
  - State is IDLE.
  - `PC`=0, `InstrCount`=0, `Halted`=0, `Fault`=0, the internal length register = 0, and the timeout counter = 0.
  - Memory contents are not cleared.
- Outputs by state:
  - `Busy` is combinational: 1 in ISSUE/WAIT, else 0.
  - `Run` is 1 only in ISSUE.
  - `DIN` equals `mem[PC[ADDR_W-1:0]]` (combinational read) in ISSUE, and 16'h0000 otherwise.
- Memory writes:
  - A write happens at an edge when `LoadEn`=1 and the state is IDLE or END.
  - `LoadEn` is ignored in ISSUE/WAIT.
- IDLE or END, handling of `Start` and `Stop`:
  - `Stop`=1 wins: stay put, no side effects.
  - Otherwise `Start`=1 does the following:
    - Clears `PC`, `InstrCount`, `Halted` and `Fault`, and latches `ProgLen`.
    - Goes to ISSUE if `ProgLen`≠0.
    - If `ProgLen`=0, goes to END with `Halted`=1.
- ISSUE: unconditionally go to WAIT after one cycle and clear the timeout counter. `Stop` in ISSUE is recorded in a sticky `stop_pend` flag.
- WAIT, when `Done`=1 at an edge:
  - `InstrCount`+1 and `PC`+1.
  - If the new `PC` equals the latched length, go to END with `Halted`=1.
  - Else if `stop_pend` or `Stop` is set, go to IDLE and clear `stop_pend`.
  - Else go to ISSUE.
- WAIT, when `Done`=0:
  - The timeout counter increments.
  - When the counter reaches `TIMEOUT`-1 and `Done`=0, go to END with `Fault`=1; `PC` and `InstrCount` are unchanged.
- An instruction is never aborted mid-execution by `Stop`. Only reset interrupts WAIT.
- `PC` never exceeds the latched length, so no wrap-around occurs.

## Timing
- Per instruction, the stage spends 1 ISSUE cycle followed by the processor's execute cycles in WAIT:
  - mv and mvt: 2 cycles total.
  - add and sub: 4 cycles total.
- There are no idle cycles between instructions: ISSUE follows the `Done` edge immediately.
- From `Start` to the first `Run`: `Start` sampled at edge E0, `Run`=1 during the cycle after E0.
- `Run` and `DIN` change only on clock edges. The processor samples `DIN` at the edge that ends ISSUE.
- `Done` is sampled only in WAIT. `Done`=1 seen in any other state is ignored.
- `Halted`, `Fault` and `PC` update at the same edge as the state transition that causes them.
- Reset mid-WAIT: the stage is in IDLE after the reset edge. `Resetn` is shared with the processor, so both restart consistently.

## Test plan
- Three-instruction program, driven into the real `proc`:
  - Load mem[0]=0x1005 (mv r0,#5), mem[1]=0x3212 (mvt r1,#0x12), mem[2]=0x5003 (add r0,#3); set `ProgLen`=3 and pulse `Start`.
  - `Run` pulses in cycles 1, 3 and 5 after `Start`.
  - `Halted`=1 and `InstrCount`=3 at cycle 9; processor r0=8, r1=0x1200.
- `Stop` during the add (set mem[3]=0x6001, `ProgLen`=4):
  - `Stop` asserted for 1 cycle in the second WAIT cycle of the add.
  - The add completes (`InstrCount`=3), the stage returns to IDLE with `PC`=3, and no further `Run` occurs.
- Timeout: use a `Done`-stuck-low processor model with `TIMEOUT`=8.
  - Expect `Fault`=1 exactly 8 WAIT cycles after ISSUE, `PC`=0 and `InstrCount`=0.
- `ProgLen`=0 with `Start`: `Halted`=1 the next cycle, and `Run` is never asserted.
- Load protection:
  - `LoadEn` to address 1 with 0xFFFF while `Busy` leaves mem[1] unchanged.
  - The same write in END takes effect.
- Simultaneous events and reset:
  - `Start`=`Stop`=1 in IDLE leaves the stage in IDLE.
  - `Resetn`=0 mid-WAIT: after the reset edge `PC`=0, `InstrCount`=0, `Run`=0, `DIN`=0, and memory is intact.
